// File: rtl/backtrack_unwinder.sv
// ============================================================================
// backtrack_unwinder: drains trail_manager's pop stream on backtrack, clearing
// assignments, saving phases and queueing variables for heap re-insertion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module backtrack_unwinder #(
    parameter int MAX_VARS   = 16,
    parameter int FIFO_DEPTH = MAX_VARS,
    parameter int VAR_W      = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bt_start,
    input  logic [15:0]                 bt_target_level,
    input  logic                        clear_all,
    output logic                        backtrack_en,
    output logic [15:0]                 backtrack_to_level,
    input  logic                        backtrack_valid,
    input  logic [VAR_W-1:0]            backtrack_var,
    input  logic                        backtrack_value,
    input  logic                        backtrack_is_decision,
    input  logic                        backtrack_done,
    output logic                        unassign_valid,
    output logic [VAR_W-1:0]            unassign_var,
    output logic                        phase_we,
    output logic [$clog2(MAX_VARS)-1:0] phase_addr,
    output logic                        phase_wdata,
    output logic                        reinsert_valid,
    input  logic                        reinsert_ready,
    output logic [VAR_W-1:0]            reinsert_var,
    output logic                        busy,
    output logic                        bt_complete,
    output logic [15:0]                 pops_count,
    output logic [15:0]                 decisions_popped,
    output logic                        overflow_err,
    output logic                        range_err
);

    localparam int AW = $clog2(MAX_VARS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [VAR_W-1:0] MAX_V  = VAR_W'(MAX_VARS);
    localparam logic [CW-1:0]    FULL_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_POP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d, complete_q, complete_d, busy_q, busy_d;
    logic [15:0]      level_q, level_d, pops_q, pops_d, dec_q, dec_d;
    logic             beat_v_q, beat_v_d, beat_val_q, beat_val_d, beat_dec_q, beat_dec_d;
    logic [VAR_W-1:0] beat_var_q, beat_var_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, rng_q, rng_d;
    logic [VAR_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic var_ok, push, pop;

    always_comb begin
        var_ok = (beat_var_q != '0) && (beat_var_q < MAX_V);
        pop    = (count_q != '0) && reinsert_ready;
        // Trail cannot stall, so a push into a full FIFO without a same-cycle pop is dropped.
        push   = beat_v_q && var_ok && ((count_q != FULL_C) || pop);

        state_d    = state_q;
        level_d    = level_q;
        pops_d     = pops_q;
        dec_d      = dec_q;
        ovf_d      = ovf_q | (beat_v_q && var_ok && (count_q == FULL_C) && !pop);
        rng_d      = rng_q | (beat_v_q && !var_ok);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        beat_v_d   = (state_q == S_POP) && backtrack_valid;
        beat_var_d = backtrack_var;
        beat_val_d = backtrack_value;
        beat_dec_d = backtrack_is_decision;

        if (beat_v_d) begin
            pops_d = pops_q + 16'd1;
            dec_d  = dec_q + 16'(backtrack_is_decision);
        end

        case (state_q)
            S_IDLE: begin
                if (bt_start) begin
                    level_d = bt_target_level;
                    pops_d  = '0;
                    dec_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_POP;
            S_POP:   if (backtrack_done) state_d = S_DRAIN;
            S_DRAIN: if (!beat_v_q && (count_q == '0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (clear_all) begin
            state_d  = S_IDLE;
            beat_v_d = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        en_d       = (state_d == S_ISSUE);
        complete_d = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            level_q    <= '0;
            pops_q     <= '0;
            dec_q      <= '0;
            beat_v_q   <= 1'b0;
            beat_var_q <= '0;
            beat_val_q <= 1'b0;
            beat_dec_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rng_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            complete_q <= complete_d;
            busy_q     <= busy_d;
            level_q    <= level_d;
            pops_q     <= pops_d;
            dec_q      <= dec_d;
            beat_v_q   <= beat_v_d;
            beat_var_q <= beat_var_d;
            beat_val_q <= beat_val_d;
            beat_dec_q <= beat_dec_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rng_q      <= rng_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear_all) begin
            fifo_mem_q[wr_ptr_q] <= beat_var_q;
        end
    end

    assign backtrack_en       = en_q;
    assign backtrack_to_level = level_q;
    assign unassign_valid     = beat_v_q;
    assign unassign_var       = beat_var_q;
    assign phase_we           = beat_v_q && var_ok;
    assign phase_addr         = beat_var_q[AW-1:0];
    assign phase_wdata        = beat_val_q;
    assign reinsert_valid     = (count_q != '0);
    assign reinsert_var       = fifo_mem_q[rd_ptr_q];
    assign busy               = busy_q;
    assign bt_complete        = complete_q;
    assign pops_count         = pops_q;
    assign decisions_popped   = dec_q;
    assign overflow_err       = ovf_q;
    assign range_err          = rng_q;

    // beat_dec_q is kept alongside the beat for debug visibility only.
    logic unused_dec;
    assign unused_dec = beat_dec_q;

endmodule

`default_nettype wire

// File: tb/tb_backtrack_unwinder.sv
// ============================================================================
// tb_backtrack_unwinder: directed stimulus with queue scoreboard and monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_backtrack_unwinder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bt_start = 1'b0;
    logic [15:0] bt_target_level = '0;
    logic        clear_all = 1'b0;
    logic        backtrack_en;
    logic [15:0] backtrack_to_level;
    logic        backtrack_valid = 1'b0;
    logic [31:0] backtrack_var = '0;
    logic        backtrack_value = 1'b0;
    logic        backtrack_is_decision = 1'b0;
    logic        backtrack_done = 1'b0;
    logic        unassign_valid;
    logic [31:0] unassign_var;
    logic        phase_we;
    logic [3:0]  phase_addr;
    logic        phase_wdata;
    logic        reinsert_valid;
    logic        reinsert_ready = 1'b1;
    logic [31:0] reinsert_var;
    logic        busy;
    logic        bt_complete;
    logic [15:0] pops_count;
    logic [15:0] decisions_popped;
    logic        overflow_err;
    logic        range_err;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int cmp_cnt = 0;

    logic [31:0] exp_un [$];
    logic [4:0]  exp_ph [$];
    logic [31:0] exp_re [$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_var = '0;

    backtrack_unwinder #(.MAX_VARS(16), .FIFO_DEPTH(2), .VAR_W(32)) dut (
        .clk(clk), .reset(reset), .bt_start(bt_start), .bt_target_level(bt_target_level),
        .clear_all(clear_all), .backtrack_en(backtrack_en), .backtrack_to_level(backtrack_to_level),
        .backtrack_valid(backtrack_valid), .backtrack_var(backtrack_var),
        .backtrack_value(backtrack_value), .backtrack_is_decision(backtrack_is_decision),
        .backtrack_done(backtrack_done), .unassign_valid(unassign_valid),
        .unassign_var(unassign_var), .phase_we(phase_we), .phase_addr(phase_addr),
        .phase_wdata(phase_wdata), .reinsert_valid(reinsert_valid),
        .reinsert_ready(reinsert_ready), .reinsert_var(reinsert_var), .busy(busy),
        .bt_complete(bt_complete), .pops_count(pops_count),
        .decisions_popped(decisions_popped), .overflow_err(overflow_err), .range_err(range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents them.
    always @(negedge clk) begin
        if (!reset) begin
            if (unassign_valid) begin
                if (exp_un.size() == 0) check("unassign_unexpected", unassign_var, 32'hFFFF_FFFF);
                else check("unassign_var", unassign_var, exp_un.pop_front());
            end
            if (phase_we) begin
                if (exp_ph.size() == 0) check("phase_unexpected", {27'd0, phase_addr, phase_wdata}, 32'hFFFF_FFFF);
                else check("phase_write", {27'd0, phase_addr, phase_wdata}, {27'd0, exp_ph.pop_front()});
            end
            if (reinsert_valid && reinsert_ready) begin
                if (exp_re.size() == 0) check("reinsert_unexpected", reinsert_var, 32'hFFFF_FFFF);
                else check("reinsert_var", reinsert_var, exp_re.pop_front());
            end
            if (prev_stall && reinsert_valid) check("reinsert_stable", reinsert_var, prev_var);
            prev_stall = reinsert_valid && !reinsert_ready;
            prev_var   = reinsert_var;
            if (backtrack_en) en_cnt++;
            if (bt_complete) cmp_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_bt(input logic [15:0] lvl);
        bt_start = 1'b1;
        bt_target_level = lvl;
        tick();
        bt_start = 1'b0;
        check("en_pulse", {31'd0, backtrack_en}, 32'd1);
        check("busy_issue", {31'd0, busy}, 32'd1);
        check("to_level", {16'd0, backtrack_to_level}, {16'd0, lvl});
        tick();
        check("en_single", {31'd0, backtrack_en}, 32'd0);
    endtask

    task automatic beat(input logic [31:0] v, input logic val, input logic dec, input logic done,
                        input logic ph, input logic re);
        backtrack_valid = 1'b1;
        backtrack_var = v;
        backtrack_value = val;
        backtrack_is_decision = dec;
        backtrack_done = done;
        exp_un.push_back(v);
        if (ph) exp_ph.push_back({v[3:0], val});
        if (re) exp_re.push_back(v);
        tick();
        backtrack_valid = 1'b0;
        backtrack_done = 1'b0;
    endtask

    task automatic wait_complete(input int budget, output int n);
        n = 0;
        while (!bt_complete && n < budget) begin
            tick();
            n++;
        end
        check("complete_seen", {31'd0, bt_complete}, 32'd1);
        tick();
        check("complete_single", {31'd0, bt_complete}, 32'd0);
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_un_left"}, exp_un.size(), 0);
        check({tag, "_ph_left"}, exp_ph.size(), 0);
        check({tag, "_re_left"}, exp_re.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_en", {31'd0, backtrack_en}, 32'd0);
        check("rst_reinsert", {31'd0, reinsert_valid}, 32'd0);
        check("rst_pops", {16'd0, pops_count}, 32'd0);
        check("rst_level", {16'd0, backtrack_to_level}, 32'd0);
        check("rst_errs", {30'd0, overflow_err, range_err}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: two beats, ready high
        reinsert_ready = 1'b1;
        start_bt(16'd2);
        beat(32'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        beat(32'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_complete(20, n);
        check("t1_pops", {16'd0, pops_count}, 32'd2);
        check("t1_decs", {16'd0, decisions_popped}, 32'd1);
        queues_empty("t1");

        // 2: heap stalls for 5 cycles after done
        reinsert_ready = 1'b0;
        start_bt(16'd1);
        beat(32'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        beat(32'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_no_complete", {31'd0, bt_complete}, 32'd0);
            check("t2_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        reinsert_ready = 1'b1;
        wait_complete(20, n);
        check("t2_ovf_clear", {31'd0, overflow_err}, 32'd0);
        queues_empty("t2");

        // 3: three beats into a two-entry FIFO that cannot drain
        reinsert_ready = 1'b0;
        start_bt(16'd0);
        beat(32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        beat(32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        beat(32'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("t3_overflow", {31'd0, overflow_err}, 32'd1);
        reinsert_ready = 1'b1;
        wait_complete(20, n);
        check("t3_pops", {16'd0, pops_count}, 32'd3);
        queues_empty("t3");

        // 4: done with no beats, complete 3 cycles after the enable pulse
        start_bt(16'd9);
        backtrack_done = 1'b1;
        tick();
        backtrack_done = 1'b0;
        check("t4_range_clear", {31'd0, range_err}, 32'd0);
        wait_complete(20, n);
        check("t4_latency", n, 1);
        check("t4_pops", {16'd0, pops_count}, 32'd0);

        // 5: out-of-range vars
        start_bt(16'd0);
        beat(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(32'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_complete(20, n);
        check("t5_range", {31'd0, range_err}, 32'd1);
        check("t5_pops", {16'd0, pops_count}, 32'd2);
        queues_empty("t5");

        // 6: clear_all with one entry queued, then a fresh run
        reinsert_ready = 1'b0;
        start_bt(16'd3);
        beat(32'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t6_queued", {31'd0, reinsert_valid}, 32'd1);
        check("t6_queued_var", reinsert_var, 32'd9);
        clear_all = 1'b1;
        bt_start = 1'b1;
        tick();
        clear_all = 1'b0;
        bt_start = 1'b0;
        check("t6_idle", {31'd0, busy}, 32'd0);
        check("t6_flushed", {31'd0, reinsert_valid}, 32'd0);
        check("t6_err_kept", {31'd0, range_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_complete", {31'd0, bt_complete}, 32'd0);
            tick();
        end
        reinsert_ready = 1'b1;
        start_bt(16'd4);
        beat(32'd10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_complete(20, n);
        check("t6_pops", {16'd0, pops_count}, 32'd1);
        check("t6_decs", {16'd0, decisions_popped}, 32'd1);
        queues_empty("t6");

        check("en_pulses", en_cnt, 7);
        check("complete_pulses", cmp_cnt, 6);

        // Reset clears the sticky flags.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_errs", {30'd0, overflow_err, range_err}, 32'd0);
        check("rst2_pops", {16'd0, pops_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
